// File: rtl/note_seq_pkg.sv
// Shared types for the note sequencer: playback mode encoding and ping-pong direction.
package note_seq_pkg;

   typedef enum logic [1:0] {
      MODE_UP       = 2'b00,
      MODE_DOWN     = 2'b01,
      MODE_PINGPONG = 2'b10,
      MODE_HOLD     = 2'b11
   } mode_t;

   localparam logic DIR_UP   = 1'b0;
   localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/note_prescaler.sv
// Tempo prescaler: counts 0..STEP_DIV-1 while enabled and issues a tick on the last count.
module note_prescaler #(
   parameter int STEP_DIV = 4
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        enable,
   input  logic                        clear,
   output logic                        tick,
   output logic [$clog2(STEP_DIV)-1:0] count
);

   localparam int CNT_W = $clog2(STEP_DIV);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(STEP_DIV - 1);

   logic [CNT_W-1:0] count_q, count_d;

   assign tick  = enable && (count_q == LAST);
   assign count = count_q;

   always_comb begin
      count_d = count_q;
      if (clear)
         count_d = '0;
      else if (tick)
         count_d = '0;
      else if (enable)
         count_d = count_q + 1'b1;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) count_q <= '0;
      else       count_q <= count_d;
   end

endmodule

// File: rtl/note_sequencer.sv
// One-hot buzzer sequencer with up/down/ping-pong/hold modes, load and step/wrap pulses.
// Build option NOTE_SEQ_GAP_EN silences the buzzer for the first GAP_CYCLES of every note.
module note_sequencer
   import note_seq_pkg::*;
#(
   parameter int NOTES      = 8,
   parameter int STEP_DIV   = 4,
   parameter int SEL_W      = $clog2(NOTES),
   parameter int GAP_CYCLES = 1
) (
   input  logic             input_clock,
   input  logic             input_reset,
   input  logic             input_enable,
   input  logic [1:0]       input_mode,
   input  logic             input_load,
   input  logic [SEL_W-1:0] input_load_value,
   output logic [NOTES-1:0] output_buzzer,
   output logic [SEL_W-1:0] output_index,
   output logic             output_step,
   output logic             output_wrap
);

   localparam int CNT_W = $clog2(STEP_DIV);
   localparam logic [SEL_W-1:0] LAST = SEL_W'(NOTES - 1);
`ifdef NOTE_SEQ_GAP_EN
   localparam bit GAP_ON = 1'b1;
`else
   localparam bit GAP_ON = 1'b0;
`endif

   mode_t            mode;
   logic             tick;
   logic [CNT_W-1:0] presc_cnt;
   logic             gap;

   logic [SEL_W-1:0] index_q, index_d;
   logic             dir_q, dir_d;
   logic             step_q, step_d;
   logic             wrap_q, wrap_d;

   assign mode = mode_t'(input_mode);

   note_prescaler #(.STEP_DIV(STEP_DIV)) u_presc (
      .clock  (input_clock),
      .reset  (input_reset),
      .enable (input_enable),
      .clear  (input_load),
      .tick   (tick),
      .count  (presc_cnt)
   );

   always_comb begin
      index_d = index_q;
      dir_d   = dir_q;
      step_d  = 1'b0;
      wrap_d  = 1'b0;
      if (input_load) begin
         index_d = (input_load_value > LAST) ? LAST : input_load_value;
         dir_d   = DIR_UP;
      end else if (tick) begin
         step_d = 1'b1;
         case (mode)
            MODE_UP: begin
               index_d = (index_q == LAST) ? '0 : index_q + 1'b1;
               wrap_d  = (index_q == LAST);
            end
            MODE_DOWN: begin
               index_d = (index_q == '0) ? LAST : index_q - 1'b1;
               wrap_d  = (index_q == '0);
            end
            MODE_PINGPONG: begin
               if (dir_q == DIR_UP) begin
                  if (index_q == LAST) begin
                     index_d = LAST - 1'b1;
                     // With two notes the turn lands on 0, which counts as a return.
                     if (NOTES == 2) wrap_d = 1'b1;
                     else            dir_d  = DIR_DOWN;
                  end else begin
                     index_d = index_q + 1'b1;
                  end
               end else begin
                  if (index_q == '0) begin
                     index_d = SEL_W'(1);
                     dir_d   = DIR_UP;
                     wrap_d  = 1'b1;
                  end else begin
                     // Turn around on arrival at 0 so the next move leaves upward.
                     index_d = index_q - 1'b1;
                     if (index_q == SEL_W'(1)) begin
                        dir_d  = DIR_UP;
                        wrap_d = 1'b1;
                     end
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge input_clock or posedge input_reset) begin
      if (input_reset) begin
         index_q <= '0;
         dir_q   <= DIR_UP;
         step_q  <= 1'b0;
         wrap_q  <= 1'b0;
      end else begin
         index_q <= index_d;
         dir_q   <= dir_d;
         step_q  <= step_d;
         wrap_q  <= wrap_d;
      end
   end

   assign gap = GAP_ON && (presc_cnt < CNT_W'(GAP_CYCLES));

   always_comb begin
      output_buzzer = '0;
      if (input_enable && !input_reset && !gap)
         output_buzzer[index_q] = 1'b1;
   end

   assign output_index = index_q;
   assign output_step  = step_q;
   assign output_wrap  = wrap_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer: an 8-note and a 6-note instance share stimulus.
module tb_note_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en  = 1'b1;
   logic [1:0] mode = 2'b00;
   logic       load = 1'b0;
   logic [2:0] lval = 3'd0;

   logic [7:0] buz8;
   logic [2:0] idx8;
   logic       st8, wr8;
   logic [5:0] buz6;
   logic [2:0] idx6;
   logic       st6, wr6;

   int compared   = 0;
   int mismatched = 0;
   int pp [16] = '{0,1,2,3,4,5,6,7,6,5,4,3,2,1,0,1};

   always #5 clk = ~clk;

   note_sequencer #(.NOTES(8), .STEP_DIV(4), .SEL_W(3), .GAP_CYCLES(1)) dut8 (
      .input_clock(clk), .input_reset(rst), .input_enable(en), .input_mode(mode),
      .input_load(load), .input_load_value(lval),
      .output_buzzer(buz8), .output_index(idx8), .output_step(st8), .output_wrap(wr8)
   );

   note_sequencer #(.NOTES(6), .STEP_DIV(4), .SEL_W(3), .GAP_CYCLES(1)) dut6 (
      .input_clock(clk), .input_reset(rst), .input_enable(en), .input_mode(mode),
      .input_load(load), .input_load_value(lval),
      .output_buzzer(buz6), .output_index(idx6), .output_step(st6), .output_wrap(wr6)
   );

   function automatic logic [7:0] exp_buz(input int idx, input int ph);
      logic [7:0] one;
      one = 8'h01;
`ifdef NOTE_SEQ_GAP_EN
      if (ph < 1) return 8'h00;
`endif
      return one << idx;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      compared++;
      assert (got === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      chk("rst_idx", 32'(idx8), 0);
      chk("rst_buz", 32'(buz8), 0);
      chk("rst_step", 32'(st8), 0);
      chk("rst_wrap", 32'(wr8), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
   endtask

   initial begin
      // 1: up mode, full cycle and wrap at cycle 32
      en = 1'b1; mode = 2'b00;
      do_reset();
      for (int n = 0; n <= 32; n++) begin
         chk("up_idx", 32'(idx8), 32'((n / 4) % 8));
         chk("up_buz", 32'(buz8), 32'(exp_buz((n / 4) % 8, n % 4)));
         chk("up_step", 32'(st8), 32'(n % 4 == 0 && n > 0));
         chk("up_wrap", 32'(wr8), 32'(n == 32));
         if (n < 32) tick(1);
      end

      // 2: down mode from reset
      mode = 2'b01;
      do_reset();
      tick(4);
      chk("dn_idx1", 32'(idx8), 7);
      chk("dn_buz1", 32'(buz8), 32'(exp_buz(7, 0)));
      chk("dn_wrap1", 32'(wr8), 1);
      chk("dn_step1", 32'(st8), 1);
      chk("dn6_idx1", 32'(idx6), 5);
      chk("dn6_wrap1", 32'(wr6), 1);
      tick(4);
      chk("dn_idx2", 32'(idx8), 6);
      chk("dn_wrap2", 32'(wr8), 0);

      // 3: ping-pong, wrap only on return to 0
      mode = 2'b10;
      do_reset();
      for (int k = 1; k <= 15; k++) begin
         tick(4);
         chk("pp_idx", 32'(idx8), 32'(pp[k]));
         chk("pp_wrap", 32'(wr8), 32'(k == 14));
         chk("pp_step", 32'(st8), 1);
      end

      // 4: load clamps on 6-note instance, load beats tick
      mode = 2'b00;
      do_reset();
      tick(2);
      lval = 3'd7; load = 1'b1;
      tick(1);
      load = 1'b0;
      chk("ld_idx6", 32'(idx6), 5);
      chk("ld_step6", 32'(st6), 0);
      chk("ld_wrap6", 32'(wr6), 0);
      chk("ld_idx8", 32'(idx8), 7);
      tick(3);
      chk("ld_hold6", 32'(idx6), 5);
      chk("ld_nostep6", 32'(st6), 0);
      tick(1);
      chk("ld_wrapidx6", 32'(idx6), 0);
      chk("ld_wrapst6", 32'(st6), 1);
      chk("ld_wrapwr6", 32'(wr6), 1);
      tick(3);
      lval = 3'd2; load = 1'b1;
      tick(1);
      load = 1'b0;
      chk("ldt_idx6", 32'(idx6), 2);
      chk("ldt_step6", 32'(st6), 0);
      chk("ldt_wrap6", 32'(wr6), 0);
      tick(4);
      chk("ldt_next6", 32'(idx6), 3);
      chk("ldt_nstep6", 32'(st6), 1);

      // 5: pause at prescaler 2, then resume; then hold mode
      mode = 2'b00;
      do_reset();
      tick(2);
      en = 1'b0;
      #1;
      chk("pause_buz0", 32'(buz8), 0);
      for (int i = 0; i < 10; i++) begin
         tick(1);
         chk("pause_idx", 32'(idx8), 0);
         chk("pause_step", 32'(st8), 0);
         chk("pause_buz", 32'(buz8), 0);
      end
      en = 1'b1;
      #1;
      tick(1);
      chk("res_idx", 32'(idx8), 0);
      chk("res_step", 32'(st8), 0);
      chk("res_buz", 32'(buz8), 32'(exp_buz(0, 3)));
      tick(1);
      chk("res_idx2", 32'(idx8), 1);
      chk("res_step2", 32'(st8), 1);
      mode = 2'b11;
      tick(4);
      chk("hold_idx", 32'(idx8), 1);
      chk("hold_step", 32'(st8), 1);
      chk("hold_wrap", 32'(wr8), 0);

      // 6: asynchronous reset mid-note
      mode = 2'b00;
      do_reset();
      tick(8);
      chk("pre_idx", 32'(idx8), 2);
      chk("pre_step", 32'(st8), 1);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_idx", 32'(idx8), 0);
      chk("arst_step", 32'(st8), 0);
      chk("arst_wrap", 32'(wr8), 0);
      chk("arst_buz", 32'(buz8), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("rel_buz0", 32'(buz8), 32'(exp_buz(0, 0)));
      tick(1);
      chk("rel_buz1", 32'(buz8), 32'(exp_buz(0, 1)));
      tick(3);
      chk("rel_idx", 32'(idx8), 1);
      chk("rel_buz2", 32'(buz8), 32'(exp_buz(1, 0)));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
